// File: rtl/ysyx_csr_pkg.sv
// ============================================================================
// Module   : ysyx_csr_pkg
// Brief    : Machine-mode CSR addresses, mstatus field positions and the
//            trap/mret sequencer state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CSR_WR      = 3'd1,
        ST_TRAP_EPC    = 3'd2,
        ST_TRAP_CAUSE  = 3'd3,
        ST_TRAP_STATUS = 3'd4,
        ST_MRET_STATUS = 3'd5,
        ST_REDIRECT    = 3'd6
    } csr_trap_state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_csr_trap_vec.sv
// ============================================================================
// Module   : ysyx_csr_trap_vec
// Brief    : Combinational trap target from mtvec and mcause (direct or
//            vectored for interrupts).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_csr_trap_vec #(
    parameter int BIT_W       = 32,
    parameter int VECTORED_EN = 0
) (
    input  logic [BIT_W-1:0] mtvec,
    input  logic [BIT_W-1:0] cause,
    output logic [BIT_W-1:0] target_pc
);

    logic [BIT_W-1:0] w_base;
    assign w_base = {mtvec[BIT_W-1:2], 2'b00};

    generate
        if (VECTORED_EN != 0) begin : g_vectored
            // The shifted cause is truncated to BIT_W, so its top code bit drops out.
            logic w_unused_bit;
            assign w_unused_bit = cause[BIT_W-2];

            always_comb begin
                target_pc = w_base;
                if (mtvec[1:0] == 2'b01 && cause[BIT_W-1]) begin
                    target_pc = w_base + {cause[BIT_W-3:0], 2'b00};
                end
            end
        end else begin : g_direct
            logic w_unused_bits;
            assign w_unused_bits = ^{cause, mtvec[1:0]};
            assign target_pc     = w_base;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ysyx_csr_trap_ctrl.sv
// ============================================================================
// Module   : ysyx_csr_trap_ctrl
// Brief    : Owns the CSR file write port; serialises CSR-instruction writes,
//            trap entry and mret, ending traps/mret with an IFU redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_csr_trap_ctrl
    import ysyx_csr_pkg::*;
#(
    parameter int BIT_W       = 32,
    parameter int R_W         = 12,
    parameter int VECTORED_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_req_valid,
    output logic             csr_req_ready,
    input  logic [R_W-1:0]   csr_req_addr,
    input  logic [BIT_W-1:0] csr_req_data,
    input  logic             trap_valid,
    output logic             trap_ready,
    input  logic [BIT_W-1:0] trap_pc,
    input  logic [BIT_W-1:0] trap_cause,
    input  logic             mret_valid,
    output logic             mret_ready,
    input  logic [BIT_W-1:0] mstatus_i,
    input  logic [BIT_W-1:0] mtvec_i,
    input  logic [BIT_W-1:0] mepc_i,
    output logic             csr_wen,
    output logic [R_W-1:0]   csr_waddr,
    output logic [BIT_W-1:0] csr_wdata,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [BIT_W-1:0] redirect_pc,
    output logic             busy
);

    csr_trap_state_t  r_state;
    csr_trap_state_t  w_state_nxt;
    logic [BIT_W-1:0] r_pc;
    logic [BIT_W-1:0] r_cause;
    logic [R_W-1:0]   r_addr;
    logic [BIT_W-1:0] r_data;
    logic [BIT_W-1:0] r_redirect_pc;
    logic [BIT_W-1:0] w_redirect_nxt;
    logic [BIT_W-1:0] w_trap_target;
    logic [BIT_W-1:0] w_trap_status;
    logic [BIT_W-1:0] w_mret_status;

    ysyx_csr_trap_vec #(
        .BIT_W       (BIT_W),
        .VECTORED_EN (VECTORED_EN)
    ) u_trap_vec (
        .mtvec     (mtvec_i),
        .cause     (r_cause),
        .target_pc (w_trap_target)
    );

    always_comb begin
        w_trap_status                                = mstatus_i;
        w_trap_status[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        w_trap_status[MSTATUS_MIE]                   = 1'b0;
        w_trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_mret_status               = mstatus_i;
        w_mret_status[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        w_mret_status[MSTATUS_MPIE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_state_nxt    = r_state;
        csr_req_ready  = 1'b0;
        trap_ready     = 1'b0;
        mret_ready     = 1'b0;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        w_redirect_nxt = r_redirect_pc;
        case (r_state)
            ST_IDLE: begin
                if (rst_n) begin
                    if (trap_valid) begin
                        trap_ready  = 1'b1;
                        w_state_nxt = ST_TRAP_EPC;
                    end else if (mret_valid) begin
                        mret_ready  = 1'b1;
                        w_state_nxt = ST_MRET_STATUS;
                    end else if (csr_req_valid) begin
                        csr_req_ready = 1'b1;
                        w_state_nxt   = ST_CSR_WR;
                    end
                end
            end
            ST_CSR_WR: begin
                csr_wen     = 1'b1;
                csr_waddr   = r_addr;
                csr_wdata   = r_data;
                w_state_nxt = ST_IDLE;
            end
            ST_TRAP_EPC: begin
                csr_wen     = 1'b1;
                csr_waddr   = R_W'(CSR_MEPC);
                csr_wdata   = r_pc & ~BIT_W'(3);
                w_state_nxt = ST_TRAP_CAUSE;
            end
            ST_TRAP_CAUSE: begin
                csr_wen     = 1'b1;
                csr_waddr   = R_W'(CSR_MCAUSE);
                csr_wdata   = r_cause;
                w_state_nxt = ST_TRAP_STATUS;
            end
            ST_TRAP_STATUS: begin
                csr_wen        = 1'b1;
                csr_waddr      = R_W'(CSR_MSTATUS);
                csr_wdata      = w_trap_status;
                w_redirect_nxt = w_trap_target;
                w_state_nxt    = ST_REDIRECT;
            end
            ST_MRET_STATUS: begin
                csr_wen        = 1'b1;
                csr_waddr      = R_W'(CSR_MSTATUS);
                csr_wdata      = w_mret_status;
                w_redirect_nxt = mepc_i;
                w_state_nxt    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_cause       <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (trap_ready) begin
                r_pc    <= trap_pc;
                r_cause <= trap_cause;
            end
            if (csr_req_ready) begin
                r_addr <= csr_req_addr;
                r_data <= csr_req_data;
            end
            r_redirect_pc <= w_redirect_nxt;
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_csr_trap_ctrl.sv
// ============================================================================
// Module   : tb_ysyx_csr_trap_ctrl
// Brief    : Directed bench with write/redirect scoreboard for the CSR trap
//            sequencer, direct and vectored instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req_valid, trap_valid, mret_valid, redirect_ready;
    logic [11:0] csr_req_addr;
    logic [31:0] csr_req_data, trap_pc, trap_cause, mstatus_i, mtvec_i, mepc_i;

    logic        csr_req_ready, trap_ready, mret_ready, csr_wen, redirect_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;

    logic        v_csr_req_ready, v_trap_ready, v_mret_ready, v_csr_wen, v_redirect_valid, v_busy;
    logic [11:0] v_csr_waddr;
    logic [31:0] v_csr_wdata, v_redirect_pc;

    always #5 clk = ~clk;

    ysyx_csr_trap_ctrl #(.BIT_W(32), .R_W(12), .VECTORED_EN(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_addr(csr_req_addr), .csr_req_data(csr_req_data),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mret_ready(mret_ready),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    ysyx_csr_trap_ctrl #(.BIT_W(32), .R_W(12), .VECTORED_EN(1)) dut_vec (
        .clk(clk), .rst_n(rst_n),
        .csr_req_valid(csr_req_valid), .csr_req_ready(v_csr_req_ready),
        .csr_req_addr(csr_req_addr), .csr_req_data(csr_req_data),
        .trap_valid(trap_valid), .trap_ready(v_trap_ready),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .mret_valid(mret_valid), .mret_ready(v_mret_ready),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_wen(v_csr_wen), .csr_waddr(v_csr_waddr), .csr_wdata(v_csr_wdata),
        .redirect_valid(v_redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(v_redirect_pc), .busy(v_busy)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_t;

    wr_t  wq[$];
    rd_t  rq[$];
    wr_t  m_w;
    rd_t  m_r;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fail_evt(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed event, expected none (cycle %0d)", tag, cyc);
    endtask

    task automatic wait_acc(input int kind, output int t);
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((kind == 0 && trap_ready) || (kind == 1 && mret_ready) ||
                (kind == 2 && csr_req_ready)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_evt("accept_timeout");
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 100 && cyc < n; i++) @(negedge clk);
    endtask

    task automatic push_trap(input int t, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] status, input logic [31:0] target);
        wq.push_back('{12'h341, pc & ~32'h3, t + 1});
        wq.push_back('{12'h342, cause, t + 2});
        wq.push_back('{12'h300, status, t + 3});
        rq.push_back('{target, t + 4});
    endtask

    // Scoreboard: every write and every new redirect must match the next expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv <= 1'b0;
        end else begin
            if (csr_wen) begin
                if (wq.size() == 0) begin
                    fail_evt("unexpected_wen");
                end else begin
                    m_w = wq.pop_front();
                    chk("wr_addr", {20'h0, csr_waddr}, {20'h0, m_w.addr});
                    chk("wr_data", csr_wdata, m_w.data);
                    chk("wr_cycle", cyc, m_w.cyc);
                end
            end
            if (redirect_valid && !prev_rv) begin
                if (rq.size() == 0) begin
                    fail_evt("unexpected_redirect");
                end else begin
                    m_r = rq.pop_front();
                    chk("redir_pc", redirect_pc, m_r.pc);
                    chk("redir_cycle", cyc, m_r.cyc);
                end
            end
            prev_rv <= redirect_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t2, t3;
        rst_n = 1'b0; csr_req_valid = 0; mret_valid = 0; redirect_ready = 1;
        csr_req_addr = '0; csr_req_data = '0; trap_pc = '0; trap_cause = '0;
        mstatus_i = '0; mtvec_i = '0; mepc_i = '0;
        trap_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_trap_ready", trap_ready, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_waddr", csr_waddr, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_busy", busy, 0);
        trap_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain trap entry
        trap_pc = 32'h8000_0104; trap_cause = 32'd11; mstatus_i = 32'h8; mtvec_i = 32'h8000_1000;
        trap_valid = 1;
        wait_acc(0, t);
        push_trap(t, 32'h8000_0104, 32'hB, 32'h1880, 32'h8000_1000);
        @(posedge clk); #1 trap_valid = 0;
        wait_cyc(t + 5);
        chk("trap_idle_after", busy, 0);

        // mret
        @(posedge clk); #1;
        mstatus_i = 32'h1880; mepc_i = 32'h8000_0108; mret_valid = 1;
        wait_acc(1, t);
        wq.push_back('{12'h300, 32'h1888, t + 1});
        rq.push_back('{32'h8000_0108, t + 2});
        @(posedge clk); #1 mret_valid = 0;
        wait_cyc(t + 3);
        chk("mret_idle_after", busy, 0);

        // Back-to-back explicit CSR writes
        @(posedge clk); #1;
        csr_req_addr = 12'h305; csr_req_data = 32'h1234_5678; csr_req_valid = 1;
        wait_acc(2, t);
        wq.push_back('{12'h305, 32'h1234_5678, t + 1});
        @(posedge clk); #1;
        csr_req_addr = 12'h340; csr_req_data = 32'hCAFE_F00D;
        wait_acc(2, t2);
        chk("csr_b2b_accept_cycle", t2, t + 2);
        wq.push_back('{12'h340, 32'hCAFE_F00D, t2 + 1});
        @(posedge clk); #1 csr_req_valid = 0;

        // All three requests at once
        @(posedge clk); #1;
        trap_pc = 32'h8000_0200; trap_cause = 32'd5; mstatus_i = 32'hA000_0002;
        mtvec_i = 32'h8000_2000; mepc_i = 32'h8000_0300;
        csr_req_addr = 12'h341; csr_req_data = 32'h1111_0000;
        trap_valid = 1; mret_valid = 1; csr_req_valid = 1;
        wait_acc(0, t);
        chk("prio_mret_ready", mret_ready, 0);
        chk("prio_csr_ready", csr_req_ready, 0);
        push_trap(t, 32'h8000_0200, 32'd5, 32'hA000_1802, 32'h8000_2000);
        @(posedge clk); #1 trap_valid = 0;
        wait_acc(1, t2);
        chk("prio_mret_cycle", t2, t + 5);
        chk("prio_csr_ready_at_mret", csr_req_ready, 0);
        wq.push_back('{12'h300, 32'hA000_0082, t2 + 1});
        rq.push_back('{32'h8000_0300, t2 + 2});
        @(posedge clk); #1 mret_valid = 0;
        wait_acc(2, t3);
        chk("prio_csr_cycle", t3, t2 + 3);
        wq.push_back('{12'h341, 32'h1111_0000, t3 + 1});
        @(posedge clk); #1 csr_req_valid = 0;
        wait_cyc(t3 + 2);

        // Redirect backpressure, unaligned trap pc
        @(posedge clk); #1;
        redirect_ready = 0;
        trap_pc = 32'h8000_0207; trap_cause = 32'd2; mstatus_i = 32'h0; mtvec_i = 32'h8000_3000;
        trap_valid = 1;
        wait_acc(0, t);
        push_trap(t, 32'h8000_0204, 32'd2, 32'h1800, 32'h8000_3000);
        @(posedge clk); #1 trap_valid = 0;
        wait_cyc(t + 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_redirect_valid", redirect_valid, 1);
            chk("bp_redirect_pc", redirect_pc, 32'h8000_3000);
            chk("bp_no_wen", csr_wen, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1 redirect_ready = 1;
        @(negedge clk);
        chk("bp_handshake_valid", redirect_valid, 1);
        @(negedge clk);
        chk("bp_released_busy", busy, 0);
        chk("bp_released_valid", redirect_valid, 0);

        // Vectored interrupt, then vectored mtvec with an exception cause
        @(posedge clk); #1;
        mtvec_i = 32'h8000_1001; trap_cause = 32'h8000_0007; mstatus_i = 32'h88;
        trap_pc = 32'h8000_0400; trap_valid = 1;
        wait_acc(0, t);
        push_trap(t, 32'h8000_0400, 32'h8000_0007, 32'h1880, 32'h8000_1000);
        @(posedge clk); #1 trap_valid = 0;
        wait_cyc(t + 4);
        chk("vec_irq_valid", v_redirect_valid, 1);
        chk("vec_irq_pc", v_redirect_pc, 32'h8000_101C);
        @(posedge clk); #1;
        trap_cause = 32'h2; trap_valid = 1;
        wait_acc(0, t);
        push_trap(t, 32'h8000_0400, 32'h2, 32'h1880, 32'h8000_1000);
        @(posedge clk); #1 trap_valid = 0;
        wait_cyc(t + 4);
        chk("vec_exc_pc", v_redirect_pc, 32'h8000_1000);

        // Reset during TRAP_CAUSE
        @(posedge clk); #1;
        trap_pc = 32'h8000_0500; trap_cause = 32'd3; mstatus_i = 32'h8; mtvec_i = 32'h8000_1000;
        trap_valid = 1;
        wait_acc(0, t);
        wq.push_back('{12'h341, 32'h8000_0500, t + 1});
        @(posedge clk); #1 trap_valid = 0;
        @(posedge clk); #1 rst_n = 0;
        #1;
        chk("mid_rst_wen", csr_wen, 0);
        chk("mid_rst_waddr", csr_waddr, 0);
        chk("mid_rst_wdata", csr_wdata, 0);
        chk("mid_rst_redirect_valid", redirect_valid, 0);
        chk("mid_rst_redirect_pc", redirect_pc, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_redirect_valid", redirect_valid, 0);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
